// File: rtl/cpu_debug_ocimem_ctrl.sv
// cpu_debug_ocimem_ctrl: turns debug-slave ocimem strobes into single-word Avalon-MM debug RAM accesses.
// Define CPU_DEBUG_OCIMEM_TIMEOUT_EN to abort accesses that stall for TIMEOUT cycles.
module cpu_debug_ocimem_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_read,
  output logic              ram_write,
  output logic [31:0]       ram_writedata,
  input  logic [31:0]       ram_readdata,
  input  logic              ram_waitrequest,
  input  logic              ram_readdatavalid,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);
  localparam logic [1:0] IDLE = 2'd0, RD_REQ = 2'd1, RD_WAIT = 2'd2, WR_REQ = 2'd3;
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q, mon_d_d, jdo_q, jdo_d;
  logic              rd_q, rd_d, wr_q, wr_d, rdy_q, rdy_d, err_q, err_d, inc_q, inc_d;
  logic              a_q, a_d, b_q, b_d, c_q, c_d;
  logic              any_strobe, accept;
  logic              unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};
  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  // A strobe is taken only when idle with nothing staged; anything else is an overrun.
  assign accept = (state_q == IDLE) && !(a_q | b_q | c_q);
`ifdef CPU_DEBUG_OCIMEM_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
`else
  localparam int unused_timeout = TIMEOUT;
`endif
  always_comb begin
    state_d = state_q;
    mon_a_d = mon_a_q;
    mon_d_d = mon_d_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    rdy_d   = rdy_q;
    err_d   = err_q;
    inc_d   = inc_q;
    a_d     = accept & take_action_ocimem_a;
    b_d     = accept & take_action_ocimem_b & !take_action_ocimem_a;
    c_d     = accept & take_no_action_ocimem_a & !take_action_ocimem_a & !take_action_ocimem_b;
    jdo_d   = (accept && any_strobe) ? jdo[34:3] : jdo_q;
    case (state_q)
      IDLE: begin
        if (a_q) begin
          mon_a_d = ADDR_W'(jdo_q[22:15]);
          err_d   = jdo_q[31] ? 1'b0 : err_q;
          if (jdo_q[14]) begin
            state_d = RD_REQ;
            rd_d    = 1'b1;
            rdy_d   = 1'b0;
            inc_d   = 1'b0;
          end
        end else if (b_q) begin
          mon_d_d = jdo_q;
          state_d = WR_REQ;
          wr_d    = 1'b1;
          rdy_d   = 1'b0;
        end else if (c_q) begin
          state_d = RD_REQ;
          rd_d    = 1'b1;
          rdy_d   = 1'b0;
          inc_d   = 1'b1;
        end
      end
      RD_REQ: begin
        state_d = ram_waitrequest ? RD_REQ : RD_WAIT;
        rd_d    = ram_waitrequest;
      end
      RD_WAIT: begin
        if (ram_readdatavalid) begin
          mon_d_d = ram_readdata;
          mon_a_d = inc_q ? mon_a_q + ADDR_W'(1) : mon_a_q;
          state_d = IDLE;
          rdy_d   = 1'b1;
        end
      end
      default: begin
        if (!ram_waitrequest) begin
          mon_a_d = mon_a_q + ADDR_W'(1);
          wr_d    = 1'b0;
          state_d = IDLE;
          rdy_d   = 1'b1;
        end
      end
    endcase
`ifdef CPU_DEBUG_OCIMEM_TIMEOUT_EN
    cnt_d = (state_q == IDLE) ? 16'd0 : cnt_q + 16'd1;
    if (state_q != IDLE && state_d != IDLE && cnt_q == 16'(TIMEOUT - 1)) begin
      state_d = IDLE;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      rdy_d   = 1'b1;
      err_d   = 1'b1;
    end
`endif
    if (any_strobe && !accept) err_d = 1'b1;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mon_a_q <= '0;
      mon_d_q <= '0;
      jdo_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdy_q   <= 1'b1;
      err_q   <= 1'b0;
      inc_q   <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      c_q     <= 1'b0;
`ifdef CPU_DEBUG_OCIMEM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      mon_a_q <= mon_a_d;
      mon_d_q <= mon_d_d;
      jdo_q   <= jdo_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      inc_q   <= inc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
`ifdef CPU_DEBUG_OCIMEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end
  assign ram_address   = mon_a_q;
  assign ram_read      = rd_q;
  assign ram_write     = wr_q;
  assign ram_writedata = mon_d_q;
  assign MonDReg       = mon_d_q;
  assign monitor_ready = rdy_q;
  assign monitor_error = err_q;
endmodule

// File: tb/tb_cpu_debug_ocimem_ctrl.sv
// tb_cpu_debug_ocimem_ctrl: directed scenario bench for cpu_debug_ocimem_ctrl with a latency-1 RAM responder.
module tb_cpu_debug_ocimem_ctrl;
`ifdef CPU_DEBUG_OCIMEM_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif
  logic        clk = 1'b0, reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        sa = 1'b0, sb = 1'b0, sc = 1'b0;
  logic [7:0]  ram_address;
  logic        ram_read, ram_write, ram_readdatavalid;
  logic [31:0] ram_writedata, MonDReg;
  logic [31:0] ram_readdata = '0;
  logic        ram_waitrequest = 1'b0;
  logic        monitor_ready, monitor_error;
  logic        rv_q = 1'b0, rv_extra = 1'b0;
  logic [31:0] last_d;
  int vec = 0, bad = 0, reads = 0;

  cpu_debug_ocimem_ctrl #(.ADDR_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(sa), .take_action_ocimem_b(sb), .take_no_action_ocimem_a(sc),
    .ram_address(ram_address), .ram_read(ram_read), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_readdata(ram_readdata),
    .ram_waitrequest(ram_waitrequest), .ram_readdatavalid(ram_readdatavalid),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;
  assign ram_readdatavalid = rv_q | rv_extra;
  always @(posedge clk) begin
    rv_q <= ram_read && !ram_waitrequest;
    if (ram_read && !ram_waitrequest) reads <= reads + 1;
  end

  function automatic logic [37:0] ja(input logic clr, input logic [7:0] ad, input logic rd);
    return {3'b0, clr, 8'h00, ad, rd, 17'h0};
  endfunction
  function automatic logic [37:0] jb(input logic [31:0] d);
    return {3'b0, d, 3'b0};
  endfunction
  task automatic pulse(input logic a, input logic b, input logic c, input logic [37:0] j);
    sa = a; sb = b; sc = c; jdo = j;
    @(negedge clk);
    sa = 1'b0; sb = 1'b0; sc = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    vec++;
    if ({ram_address, ram_read, ram_write, ram_writedata, MonDReg, monitor_ready, monitor_error} !== {8'h00, 2'b00, 64'h0, 2'b10}) begin
      bad++; $display("FAIL reset outputs got a=%h r=%b w=%b d=%h ready=%b err=%b want a=00 r=0 w=0 d=0 ready=1 err=0",
                      ram_address, ram_read, ram_write, MonDReg, monitor_ready, monitor_error);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_addr_load;
    int n = 0;
    pulse(1'b1, 1'b0, 1'b0, ja(1'b0, 8'h10, 1'b0));
    repeat (3) begin @(negedge clk); if (ram_read || ram_write || !monitor_ready) n++; end
    vec++;
    if (ram_address !== 8'h10) begin bad++; $display("FAIL addr_load address got %h want 10", ram_address); end
    vec++;
    if (n !== 0) begin bad++; $display("FAIL addr_load request_or_busy cycles got %0d want 0", n); end
  endtask

  task automatic test_write_stall;
    int n = 0;
    ram_waitrequest = 1'b1;
    pulse(1'b0, 1'b1, 1'b0, jb(32'hDEADBEEF));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ram_write && ram_address == 8'h10 && ram_writedata == 32'hDEADBEEF && !monitor_ready) n++;
      if (i == 3) ram_waitrequest = 1'b0;
    end
    vec++;
    if (n !== 4) begin bad++; $display("FAIL write_stall held_cycles got %0d want 4", n); end
    @(negedge clk);
    vec++;
    if ({ram_write, ram_address, monitor_ready} !== {1'b0, 8'h11, 1'b1}) begin
      bad++; $display("FAIL write_stall done got w=%b a=%h ready=%b want w=0 a=11 ready=1", ram_write, ram_address, monitor_ready);
    end
  endtask

  task automatic test_priority;
    int n = 0;
    pulse(1'b1, 1'b1, 1'b1, ja(1'b0, 8'h40, 1'b0));
    repeat (4) begin @(negedge clk); if (ram_write || ram_read) n++; end
    vec++;
    if ({n[3:0], ram_address, monitor_ready, monitor_error} !== {4'd0, 8'h40, 2'b10}) begin
      bad++; $display("FAIL priority got req=%0d a=%h ready=%b err=%b want req=0 a=40 ready=1 err=0", n, ram_address, monitor_ready, monitor_error);
    end
  endtask

  task automatic test_read_wrap;
    pulse(1'b1, 1'b0, 1'b0, ja(1'b0, 8'hFF, 1'b0));
    @(negedge clk);
    ram_readdata = 32'h12345678;
    pulse(1'b0, 1'b0, 1'b1, '0);
    @(negedge clk);
    vec++;
    if ({ram_read, monitor_ready, ram_address} !== {2'b10, 8'hFF}) begin
      bad++; $display("FAIL read_wrap n+1 got r=%b ready=%b a=%h want r=1 ready=0 a=ff", ram_read, monitor_ready, ram_address);
    end
    @(negedge clk);
    vec++;
    if ({ram_read, monitor_ready} !== 2'b00) begin bad++; $display("FAIL read_wrap n+2 got r=%b ready=%b want r=0 ready=0", ram_read, monitor_ready); end
    @(negedge clk);
    vec++;
    if ({monitor_ready, MonDReg, ram_address} !== {1'b1, 32'h12345678, 8'h00}) begin
      bad++; $display("FAIL read_wrap n+3 got ready=%b d=%h a=%h want ready=1 d=12345678 a=00", monitor_ready, MonDReg, ram_address);
    end
  endtask

  task automatic test_read_no_inc;
    ram_readdata = 32'hAABBCCDD;
    pulse(1'b1, 1'b0, 1'b0, ja(1'b0, 8'h20, 1'b1));
    repeat (3) @(negedge clk);
    vec++;
    if ({monitor_ready, MonDReg, ram_address} !== {1'b1, 32'hAABBCCDD, 8'h20}) begin
      bad++; $display("FAIL read_no_inc got ready=%b d=%h a=%h want ready=1 d=aabbccdd a=20", monitor_ready, MonDReg, ram_address);
    end
  endtask

  task automatic test_overrun;
    int r0 = reads;
    ram_readdata = 32'h00000055;
    pulse(1'b0, 1'b0, 1'b1, '0);
    repeat (2) @(negedge clk);
    pulse(1'b0, 1'b0, 1'b1, '0);
    repeat (4) @(negedge clk);
    vec++;
    if (reads - r0 !== 1) begin bad++; $display("FAIL overrun read_count got %0d want 1", reads - r0); end
    vec++;
    if ({monitor_error, monitor_ready, MonDReg, ram_address} !== {2'b11, 32'h55, 8'h21}) begin
      bad++; $display("FAIL overrun state got err=%b ready=%b d=%h a=%h want err=1 ready=1 d=55 a=21", monitor_error, monitor_ready, MonDReg, ram_address);
    end
    pulse(1'b1, 1'b0, 1'b0, ja(1'b1, 8'h21, 1'b0));
    @(negedge clk);
    vec++;
    if (monitor_error !== 1'b0) begin bad++; $display("FAIL overrun_clear err got %b want 0", monitor_error); end
  endtask

`ifdef CPU_DEBUG_OCIMEM_TIMEOUT_EN
  task automatic test_stall;
    int n = 0;
    ram_waitrequest = 1'b1;
    pulse(1'b0, 1'b0, 1'b1, '0);
    repeat (12) begin @(negedge clk); if (ram_read) n++; end
    vec++;
    if (n !== 8) begin bad++; $display("FAIL timeout read_cycles got %0d want 8", n); end
    vec++;
    if ({monitor_error, monitor_ready, ram_read, ram_address, MonDReg} !== {3'b110, 8'h21, 32'h55}) begin
      bad++; $display("FAIL timeout state got err=%b ready=%b r=%b a=%h d=%h want err=1 ready=1 r=0 a=21 d=55",
                      monitor_error, monitor_ready, ram_read, ram_address, MonDReg);
    end
    ram_waitrequest = 1'b0;
    last_d = 32'h55;
  endtask
`else
  task automatic test_stall;
    ram_readdata = 32'h00000066;
    ram_waitrequest = 1'b1;
    pulse(1'b0, 1'b0, 1'b1, '0);
    repeat (20) @(negedge clk);
    vec++;
    if ({ram_read, monitor_ready, monitor_error, ram_address} !== {3'b100, 8'h21}) begin
      bad++; $display("FAIL long_stall got r=%b ready=%b err=%b a=%h want r=1 ready=0 err=0 a=21", ram_read, monitor_ready, monitor_error, ram_address);
    end
    ram_waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    vec++;
    if ({monitor_ready, MonDReg, ram_address} !== {1'b1, 32'h66, 8'h22}) begin
      bad++; $display("FAIL long_stall done got ready=%b d=%h a=%h want ready=1 d=66 a=22", monitor_ready, MonDReg, ram_address);
    end
    last_d = 32'h66;
  endtask
`endif

  task automatic test_late_valid;
    ram_readdata = 32'hFFFF0000;
    rv_extra = 1'b1;
    @(negedge clk);
    rv_extra = 1'b0;
    @(negedge clk);
    vec++;
    if ({MonDReg, monitor_ready, ram_read} !== {last_d, 2'b10}) begin
      bad++; $display("FAIL late_valid got d=%h ready=%b r=%b want d=%h ready=1 r=0", MonDReg, monitor_ready, ram_read, last_d);
    end
  endtask

  task automatic test_reset_mid_write;
    ram_waitrequest = 1'b1;
    pulse(1'b0, 1'b1, 1'b0, jb(32'hCAFEF00D));
    @(negedge clk);
    vec++;
    if (ram_write !== 1'b1) begin bad++; $display("FAIL mid_write active got w=%b want 1", ram_write); end
    #2 reset_n = 1'b0;
    #1;
    vec++;
    if ({ram_address, ram_read, ram_write, ram_writedata, MonDReg, monitor_ready, monitor_error} !== {8'h00, 2'b00, 64'h0, 2'b10}) begin
      bad++; $display("FAIL mid_write async_reset got a=%h r=%b w=%b d=%h ready=%b err=%b want all reset values",
                      ram_address, ram_read, ram_write, MonDReg, monitor_ready, monitor_error);
    end
    @(negedge clk);
    reset_n = 1'b1;
    ram_waitrequest = 1'b0;
    @(negedge clk);
    pulse(1'b0, 1'b1, 1'b0, jb(32'h0BADC0DE));
    @(negedge clk);
    vec++;
    if ({ram_write, monitor_ready} !== 2'b10) begin bad++; $display("FAIL post_reset_write n+1 got w=%b ready=%b want w=1 ready=0", ram_write, monitor_ready); end
    @(negedge clk);
    vec++;
    if ({ram_write, monitor_ready, ram_address, ram_writedata} !== {2'b01, 8'h01, 32'h0BADC0DE}) begin
      bad++; $display("FAIL post_reset_write n+2 got w=%b ready=%b a=%h d=%h want w=0 ready=1 a=01 d=0badc0de",
                      ram_write, monitor_ready, ram_address, ram_writedata);
    end
  endtask

  initial begin
    test_reset;
    test_addr_load;
    test_write_stall;
    test_priority;
    test_read_wrap;
    test_read_no_inc;
    test_overrun;
    test_stall;
    test_late_valid;
    test_reset_mid_write;
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
